// File: rtl/rst_seq_ctrl.sv
// Releases N active-low block resets in index order, each gated on the previous ack; registered outputs.
// Build with RST_SEQ_TIMEOUT_EN to add a per-stage ack timeout that parks the sequencer in ERROR.
module rst_seq_ctrl #(
    parameter int N_STAGES       = 4,
    parameter int HOLD_CYCLES    = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int IW            = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic                sw_rst_req_i,
    input  logic [N_STAGES-1:0] stage_ack_i,
    output logic [N_STAGES-1:0] stage_rst_no,
    output logic                seq_busy_o,
    output logic                seq_done_o,
    output logic                err_o,
    output logic [IW-1:0]       err_stage_o
);

    localparam int MAXHG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAXC  = (MAXHG > TIMEOUT_CYCLES) ? MAXHG : TIMEOUT_CYCLES;
    localparam int CW    = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        HOLD,
        WAIT_ACK,
        GAP,
        DONE,
        ASSERT,
        ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [N_STAGES-1:0]   rst_q, rst_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef RST_SEQ_TIMEOUT_EN
    logic                  err_q, err_d;
    logic [IW-1:0]         es_q, es_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_i) begin
            state_q <= HOLD;
            idx_q   <= '0;
            cnt_q   <= '0;
            rst_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
            err_q   <= 1'b0;
            es_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef RST_SEQ_TIMEOUT_EN
            err_q   <= err_d;
            es_q    <= es_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        done_d  = done_q;
`ifdef RST_SEQ_TIMEOUT_EN
        err_d   = err_q;
        es_d    = es_q;
`endif
        // A request outranks any same-edge ack; ASSERT ignores it so a held request walks once.
        if (sw_rst_req_i && state_q != ASSERT) begin
            done_d             = 1'b0;
            rst_d[N_STAGES-1]  = 1'b0;
            idx_d              = IW'(N_STAGES - 1);
            cnt_d              = '0;
            state_d            = (N_STAGES == 1) ? HOLD : ASSERT;
`ifdef RST_SEQ_TIMEOUT_EN
            err_d              = 1'b0;
`endif
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        rst_d[0] = 1'b1;
                        idx_d    = '0;
                        cnt_d    = '0;
                        state_d  = WAIT_ACK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                WAIT_ACK: begin
                    if (stage_ack_i[idx_q]) begin
                        cnt_d = '0;
                        if (idx_q == IW'(N_STAGES - 1)) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = GAP;
                        end
                    end
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        err_d   = 1'b1;
                        es_d    = idx_q;
                        rst_d   = '0;
                        cnt_d   = '0;
                        state_d = ERROR;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
`endif
                end
                GAP: begin
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        idx_d        = idx_q + IW'(1);
                        rst_d[idx_d] = 1'b1;
                        cnt_d        = '0;
                        state_d      = WAIT_ACK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ASSERT: begin
                    idx_d        = idx_q - IW'(1);
                    rst_d[idx_d] = 1'b0;
                    if (idx_q == IW'(1)) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end
                end
                DONE, ERROR: begin
                end
                default: state_d = HOLD;
            endcase
        end
        busy_d = (state_d != DONE) && (state_d != ERROR);
    end

    assign stage_rst_no = rst_q;
    assign seq_busy_o   = busy_q;
    assign seq_done_o   = done_q;
`ifdef RST_SEQ_TIMEOUT_EN
    assign err_o        = err_q;
    assign err_stage_o  = es_q;
`else
    assign err_o        = 1'b0;
    assign err_stage_o  = '0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: expected output snapshots are queued per edge and checked on the falling edge.
module tb_rst_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       sw_rst_req_i;
    logic [3:0] stage_ack_i;
    logic [3:0] stage_rst_no;
    logic       seq_busy_o;
    logic       seq_done_o;
    logic       err_o;
    logic [1:0] err_stage_o;

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .N_STAGES       (4),
        .HOLD_CYCLES    (8),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .sw_rst_req_i (sw_rst_req_i),
        .stage_ack_i  (stage_ack_i),
        .stage_rst_no (stage_rst_no),
        .seq_busy_o   (seq_busy_o),
        .seq_done_o   (seq_done_o),
        .err_o        (err_o),
        .err_stage_o  (err_stage_o)
    );

    typedef struct {
        int         c;
        logic [3:0] r;
        logic       busy;
        logic       done;
        logic       err;
        logic       es_chk;
        logic [1:0] es;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected state after rising edge number e.c is compared on the following falling edge.
    always @(negedge clk) begin : chk
        exp_t e;
        while (q.size() > 0 && q[0].c <= cyc) begin
            e = q.pop_front();
            total++;
            if (e.c != cyc) begin
                bad++;
                $display("FAIL %s stale: due edge %0d checked at %0d", e.nm, e.c, cyc);
            end else if ({stage_rst_no, seq_busy_o, seq_done_o, err_o} !== {e.r, e.busy, e.done, e.err}) begin
                bad++;
                $display("FAIL %s edge %0d: rst=%b busy=%b done=%b err=%b, required rst=%b busy=%b done=%b err=%b",
                         e.nm, cyc, stage_rst_no, seq_busy_o, seq_done_o, err_o, e.r, e.busy, e.done, e.err);
            end
            if (e.es_chk && e.c == cyc) begin
                total++;
                if (err_stage_o !== e.es) begin
                    bad++;
                    $display("FAIL %s err_stage edge %0d: got %0d required %0d", e.nm, cyc, err_stage_o, e.es);
                end
            end
        end
    end

    task automatic push(input int c, input logic [3:0] r, input logic busy, input logic done,
                        input logic err, input logic es_chk, input logic [1:0] es, input string nm);
        exp_t e;
        e.c = c; e.r = r; e.busy = busy; e.done = done;
        e.err = err; e.es_chk = es_chk; e.es = es; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        if (cyc > c) begin
            total++;
            bad++;
            $display("FAIL sched: at edge %0d, required at most %0d", cyc, c);
        end
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s drain: %0d entries left, required 0", nm, q.size());
            q.delete();
        end
    endtask

    // h0: first edge at which HOLD evaluates with cnt=0; each ack returns one cycle after its release.
    task automatic run_release(input int h0, input string nm);
        logic [3:0] cur = 4'b0000;
        int         r   = h0 + 7;
        for (int k = 0; k < 4; k++) begin
            push(r - 1, cur, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, {nm, "_pre"});
            cur[k] = 1'b1;
            push(r, cur, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, {nm, "_rel"});
            wait_until(r);
            stage_ack_i[k] = 1'b1;
            if (k < 3) r = r + 1 + 2;
            else push(r + 1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, {nm, "_done"});
        end
        drain(nm);
    endtask

    task automatic push_walk(input int e, input logic [3:0] start, input logic err_chk, input string nm);
        logic [3:0] v = start;
        for (int i = 3; i >= 0; i--) begin
            v[i] = 1'b0;
            push(e + (3 - i), v, 1'b1, 1'b0, 1'b0, err_chk, 2'd0, nm);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0; sw_rst_req_i = 1'b0; stage_ack_i = 4'b0000;
        repeat (3) @(negedge clk);
        total++;
        if (stage_rst_no !== 4'b0000) begin
            bad++;
            $display("FAIL reset_rst: got %b required 0000", stage_rst_no);
        end
        total++;
        if ({seq_busy_o, seq_done_o, err_o, err_stage_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: busy=%b done=%b err=%b es=%0d required all 0",
                     seq_busy_o, seq_done_o, err_o, err_stage_o);
        end
    endtask

    task automatic test_powerup();
        int e0;
        rst_i = 1'b1;
        e0 = cyc + 1;
        push(e0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, "e0_busy");
        run_release(e0, "powerup");
    endtask

    task automatic test_sw_reseq();
        int e;
        stage_ack_i = 4'b0000;
        sw_rst_req_i = 1'b1;
        e = cyc + 1;
        push_walk(e, 4'b1111, 1'b1, "walk");
        @(negedge clk);
        sw_rst_req_i = 1'b0;
        run_release(e + 4, "reseq");
    endtask

    task automatic test_early_ack();
        int e;
        int r0;
        stage_ack_i = 4'b0100;
        sw_rst_req_i = 1'b1;
        e = cyc + 1;
        push_walk(e, 4'b1111, 1'b0, "walk2");
        @(negedge clk);
        sw_rst_req_i = 1'b0;
        r0 = e + 4 + 7;
        push(r0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "early_rel0");
        push(r0 + 5, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "early_ignored");
        wait_until(r0 + 5);
        stage_ack_i[0] = 1'b1;
        push(r0 + 7, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "early_gap");
        push(r0 + 8, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "early_rel1");
        wait_until(r0 + 8);
        drain("early");
    endtask

    task automatic test_rst_mid_gap();
        int c = cyc;
        stage_ack_i[1] = 1'b1;
        push(c + 1, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "gap_entry");
        push(c + 2, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, "rst_mid_gap");
        push(c + 3, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, "rst_held");
        wait_until(c + 1);
        rst_i = 1'b0;
        wait_until(c + 3);
        stage_ack_i = 4'b0000;
        rst_i = 1'b1;
        push(c + 4, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, "rst_e0");
        run_release(c + 4, "after_rst");
    endtask

    task automatic test_stall();
        int e;
        int r0;
        int r1;
        int e2;
        stage_ack_i = 4'b0000;
        sw_rst_req_i = 1'b1;
        e = cyc + 1;
        push_walk(e, 4'b1111, 1'b0, "walk3");
        @(negedge clk);
        sw_rst_req_i = 1'b0;
        r0 = e + 4 + 7;
        push(r0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "stall_rel0");
        wait_until(r0);
        stage_ack_i[0] = 1'b1;
        r1 = r0 + 3;
        push(r1, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "stall_rel1");
        wait_until(r1);
`ifdef RST_SEQ_TIMEOUT_EN
        push(r1 + 15, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "pre_timeout");
        push(r1 + 16, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, "timeout");
        push(r1 + 18, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, "err_sticky");
        wait_until(r1 + 18);
        stage_ack_i = 4'b0000;
        sw_rst_req_i = 1'b1;
        e2 = cyc + 1;
        push_walk(e2, 4'b0000, 1'b0, "err_walk");
`else
        push(r1 + 16, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, "no_timeout");
        push(r1 + 40, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, "wait_forever");
        wait_until(r1 + 40);
        stage_ack_i = 4'b0000;
        sw_rst_req_i = 1'b1;
        e2 = cyc + 1;
        push_walk(e2, 4'b0011, 1'b0, "stall_walk");
`endif
        @(negedge clk);
        sw_rst_req_i = 1'b0;
        run_release(e2 + 4, "recover");
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_sw_reseq();
        test_early_ack();
        test_rst_mid_gap();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
